mc_main_ctrl: RTL and testbench



---
 rtl/mc_main_ctrl.sv | 267 ++++++++++++++++++++++++++
 tb/tb_mc_main_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mc_main_ctrl.sv
// mc_main_ctrl: main control FSM of the multicycle MIPS datapath.
// Steps each instruction through fetch, decode, execute, memory and
// writeback, and drives every datapath enable and mux select.
// Apart from illegal, all outputs are decoded from the state register.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   opcode/funct/rt instruction fields from IR, sampled in DECODE
//   pc_write, pc_write_cond, pc_source     PC load control
//   iord, mem_read, mem_write, ir_write    memory / IR control
//   reg_write, reg_dst, mem_to_reg         register file write control
//   alu_src_a, alu_src_b, ext_zero, aluop  ALU operand / operation control
//   inst_done   last cycle of an instruction
//   illegal     one-cycle pulse in DECODE on an unsupported instruction
//   halted      high while trapped in HALT (ILLEGAL_TRAP = 1)
module mc_main_ctrl #(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic [4:0] rt,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       ext_zero,
  output logic [1:0] pc_source,
  output logic [3:0] aluop,
  output logic       inst_done,
  output logic       illegal,
  output logic       halted
);

  typedef enum logic [3:0] {
    FETCH    = 4'h0,
    DECODE   = 4'h1,
    MEM_ADDR = 4'h2,
    MEM_RD   = 4'h3,
    MEM_WB   = 4'h4,
    MEM_WR   = 4'h5,
    R_EX     = 4'h6,
    R_WB     = 4'h7,
    I_EX     = 4'h8,
    I_WB     = 4'h9,
    BRANCH   = 4'hA,
    JUMP     = 4'hB,
    JAL      = 4'hC,
    JR       = 4'hD,
    JALR     = 4'hE,
    HALT     = 4'hF
  } state_e;

  state_e     state_q, state_d;
  // Instruction attributes captured in DECODE so later states ignore IR.
  logic [3:0] aluop_q, aluop_d;
  logic       ext_q, ext_d;
  logic       lw_q, lw_d;

  state_e     dec_state;
  logic [3:0] dec_aluop;
  logic       dec_ext;
  logic       dec_ill;

  // Instruction dispatch from the current IR fields.
  always_comb begin
    dec_state = FETCH;
    dec_aluop = '0;
    dec_ext   = 1'b0;
    dec_ill   = 1'b0;
    case (opcode)
      6'h23, 6'h2B: dec_state = MEM_ADDR;
      6'h00: begin
        case (funct)
          6'h08:   dec_state = JR;
          6'h09:   dec_state = JALR;
          default: dec_state = R_EX;
        endcase
      end
      6'h01: begin
        if (rt == 5'd0) begin
          dec_state = BRANCH;
          dec_aluop = 4'hE;
        end else if (rt == 5'd1) begin
          dec_state = BRANCH;
          dec_aluop = 4'hF;
        end else begin
          dec_ill = 1'b1;
        end
      end
      6'h02: dec_state = JUMP;
      6'h03: dec_state = JAL;
      6'h04: begin dec_state = BRANCH; dec_aluop = 4'h1; end
      6'h05: begin dec_state = BRANCH; dec_aluop = 4'hB; end
      6'h06: begin dec_state = BRANCH; dec_aluop = 4'hD; end
      6'h07: begin dec_state = BRANCH; dec_aluop = 4'hC; end
      6'h08: begin dec_state = I_EX; dec_aluop = 4'h3; end
      6'h09: begin dec_state = I_EX; dec_aluop = 4'h4; end
      6'h0A: begin dec_state = I_EX; dec_aluop = 4'h9; end
      6'h0B: begin dec_state = I_EX; dec_aluop = 4'hA; end
      6'h0C: begin dec_state = I_EX; dec_aluop = 4'h5; dec_ext = 1'b1; end
      6'h0D: begin dec_state = I_EX; dec_aluop = 4'h6; dec_ext = 1'b1; end
      6'h0E: begin dec_state = I_EX; dec_aluop = 4'h7; dec_ext = 1'b1; end
      6'h0F: begin dec_state = I_EX; dec_aluop = 4'h8; end
      default: dec_ill = 1'b1;
    endcase
    if (dec_ill) begin
      if (ILLEGAL_TRAP) dec_state = HALT;
      else              dec_state = FETCH;
    end
  end

  always_comb begin
    state_d = state_q;
    aluop_d = aluop_q;
    ext_d   = ext_q;
    lw_d    = lw_q;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        state_d = dec_state;
        aluop_d = dec_aluop;
        ext_d   = dec_ext;
        lw_d    = (opcode == 6'h23);
      end
      MEM_ADDR: begin
        if (lw_q) state_d = MEM_RD;
        else      state_d = MEM_WR;
      end
      MEM_RD:  state_d = MEM_WB;
      R_EX:    state_d = R_WB;
      I_EX:    state_d = I_WB;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      aluop_q <= '0;
      ext_q   <= 1'b0;
      lw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      aluop_q <= aluop_d;
      ext_q   <= ext_d;
      lw_q    <= lw_d;
    end
  end

  // Outputs are gated by rst directly so no strobe survives the reset cycle.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    ext_zero      = 1'b0;
    pc_source     = 2'b00;
    aluop         = '0;
    inst_done     = 1'b0;
    illegal       = 1'b0;
    halted        = 1'b0;
    if (!rst) begin
      case (state_q)
        FETCH: begin
          mem_read  = 1'b1;
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = 2'b01;
        end
        DECODE: begin
          alu_src_b = 2'b11;
          illegal   = dec_ill;
        end
        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'b01;
          inst_done  = 1'b1;
        end
        MEM_WR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
          inst_done = 1'b1;
        end
        R_EX: begin
          alu_src_a = 1'b1;
          aluop     = 4'h2;
        end
        R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 2'b01;
          inst_done = 1'b1;
        end
        I_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          aluop     = aluop_q;
          ext_zero  = ext_q;
        end
        I_WB: begin
          reg_write = 1'b1;
          inst_done = 1'b1;
        end
        BRANCH: begin
          alu_src_a     = 1'b1;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
          aluop         = aluop_q;
          inst_done     = 1'b1;
        end
        JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'b10;
          inst_done = 1'b1;
        end
        JAL: begin
          pc_write   = 1'b1;
          pc_source  = 2'b10;
          reg_write  = 1'b1;
          reg_dst    = 2'b10;
          mem_to_reg = 2'b10;
          inst_done  = 1'b1;
        end
        JR: begin
          pc_write  = 1'b1;
          pc_source = 2'b11;
          inst_done = 1'b1;
        end
        JALR: begin
          pc_write   = 1'b1;
          pc_source  = 2'b11;
          reg_write  = 1'b1;
          reg_dst    = 2'b01;
          mem_to_reg = 2'b10;
          inst_done  = 1'b1;
        end
        HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Testbench for mc_main_ctrl: a driver issues directed per-cycle stimulus and
// queues the expected output bundle; a monitor pops and compares each cycle.
// dut_m uses ILLEGAL_TRAP = 0, dut_t uses ILLEGAL_TRAP = 1.
module tb_mc_main_ctrl;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [1:0] pc_source;
    logic [3:0] aluop;
    logic       inst_done;
    logic       illegal;
    logic       halted;
  } out_t;

  typedef enum {
    RST, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EX, R_WB,
    I_EX, I_WB, BRANCH, JUMP, JAL, JR, JALR, HALT
  } tst_e;

  typedef struct {
    out_t  exp;
    int    which;
    string nm;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_m = 1'b1, rst_t = 1'b1;
  logic [5:0] op_m = '0, fn_m = '0, op_t = '0, fn_t = '0;
  logic [4:0] rt_m = '0, rt_t = '0;

  logic       pcw_m, pcwc_m, iord_m, mrd_m, mwr_m, irw_m, rw_m, sa_m, ez_m, done_m, ill_m, hlt_m;
  logic [1:0] rd_m, m2r_m, sb_m, ps_m;
  logic [3:0] aop_m;
  logic       pcw_t, pcwc_t, iord_t, mrd_t, mwr_t, irw_t, rw_t, sa_t, ez_t, done_t, ill_t, hlt_t;
  logic [1:0] rd_t, m2r_t, sb_t_w, ps_t;
  logic [3:0] aop_t;

  mc_main_ctrl #(.ILLEGAL_TRAP(1'b0)) dut_m (
    .clk(clk), .rst(rst_m), .opcode(op_m), .funct(fn_m), .rt(rt_m),
    .pc_write(pcw_m), .pc_write_cond(pcwc_m), .iord(iord_m), .mem_read(mrd_m),
    .mem_write(mwr_m), .ir_write(irw_m), .reg_write(rw_m), .reg_dst(rd_m),
    .mem_to_reg(m2r_m), .alu_src_a(sa_m), .alu_src_b(sb_m), .ext_zero(ez_m),
    .pc_source(ps_m), .aluop(aop_m), .inst_done(done_m), .illegal(ill_m),
    .halted(hlt_m)
  );

  mc_main_ctrl #(.ILLEGAL_TRAP(1'b1)) dut_t (
    .clk(clk), .rst(rst_t), .opcode(op_t), .funct(fn_t), .rt(rt_t),
    .pc_write(pcw_t), .pc_write_cond(pcwc_t), .iord(iord_t), .mem_read(mrd_t),
    .mem_write(mwr_t), .ir_write(irw_t), .reg_write(rw_t), .reg_dst(rd_t),
    .mem_to_reg(m2r_t), .alu_src_a(sa_t), .alu_src_b(sb_t_w), .ext_zero(ez_t),
    .pc_source(ps_t), .aluop(aop_t), .inst_done(done_t), .illegal(ill_t),
    .halted(hlt_t)
  );

  out_t act_m, act_t;
  assign act_m = {pcw_m, pcwc_m, iord_m, mrd_m, mwr_m, irw_m, rw_m, rd_m, m2r_m,
                  sa_m, sb_m, ez_m, ps_m, aop_m, done_m, ill_m, hlt_m};
  assign act_t = {pcw_t, pcwc_t, iord_t, mrd_t, mwr_t, irw_t, rw_t, rd_t, m2r_t,
                  sa_t, sb_t_w, ez_t, ps_t, aop_t, done_t, ill_t, hlt_t};

  int   n_chk  = 0;
  int   n_fail = 0;
  sb_t  sb[$];
  sb_t  mon_e;

  // Expected output bundle per state, straight from the state/output table.
  function automatic out_t exp_of(input tst_e s, input logic [3:0] aop,
                                  input logic ext, input logic ill);
    out_t o;
    o = '0;
    case (s)
      FETCH:    begin o.mem_read = 1; o.ir_write = 1; o.pc_write = 1; o.alu_src_b = 2'b01; end
      DECODE:   begin o.alu_src_b = 2'b11; o.illegal = ill; end
      MEM_ADDR: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; end
      MEM_RD:   begin o.mem_read = 1; o.iord = 1; end
      MEM_WB:   begin o.reg_write = 1; o.mem_to_reg = 2'b01; o.inst_done = 1; end
      MEM_WR:   begin o.mem_write = 1; o.iord = 1; o.inst_done = 1; end
      R_EX:     begin o.alu_src_a = 1; o.aluop = 4'h2; end
      R_WB:     begin o.reg_write = 1; o.reg_dst = 2'b01; o.inst_done = 1; end
      I_EX:     begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.aluop = aop; o.ext_zero = ext; end
      I_WB:     begin o.reg_write = 1; o.inst_done = 1; end
      BRANCH:   begin o.alu_src_a = 1; o.pc_write_cond = 1; o.pc_source = 2'b01;
                      o.aluop = aop; o.inst_done = 1; end
      JUMP:     begin o.pc_write = 1; o.pc_source = 2'b10; o.inst_done = 1; end
      JAL:      begin o.pc_write = 1; o.pc_source = 2'b10; o.reg_write = 1;
                      o.reg_dst = 2'b10; o.mem_to_reg = 2'b10; o.inst_done = 1; end
      JR:       begin o.pc_write = 1; o.pc_source = 2'b11; o.inst_done = 1; end
      JALR:     begin o.pc_write = 1; o.pc_source = 2'b11; o.reg_write = 1;
                      o.reg_dst = 2'b01; o.mem_to_reg = 2'b10; o.inst_done = 1; end
      HALT:     o.halted = 1;
      default:  o = '0;
    endcase
    return o;
  endfunction

  task automatic check(input out_t a, input out_t e, input string nm);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check((mon_e.which == 1) ? act_t : act_m, mon_e.exp, mon_e.nm);
    end
  end

  // One clock cycle: drive inputs just after the rising edge, queue expectation.
  task automatic cyc(input int which, input logic r, input logic [5:0] op,
                     input logic [5:0] fn, input logic [4:0] rv, input tst_e s,
                     input logic [3:0] aop, input logic ext, input logic ill,
                     input string nm);
    sb_t e;
    @(posedge clk);
    #1;
    if (which == 0) begin
      rst_m = r; op_m = op; fn_m = fn; rt_m = rv;
    end else begin
      rst_t = r; op_t = op; fn_t = fn; rt_t = rv;
    end
    e.exp   = exp_of(s, aop, ext, ill);
    e.which = which;
    e.nm    = nm;
    sb.push_back(e);
  endtask

  // After DECODE the IR fields are scrambled: later states must use latched data.
  task automatic seq3(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rv,
                      input tst_e s3, input logic [3:0] aop, input string nm);
    cyc(0, 0, op, fn, rv, FETCH, 4'h0, 0, 0, {nm, "_fetch"});
    cyc(0, 0, op, fn, rv, DECODE, 4'h0, 0, 0, {nm, "_decode"});
    cyc(0, 0, 6'h3F, 6'h3F, 5'h1F, s3, aop, 0, 0, {nm, "_exec"});
  endtask

  task automatic seq4(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rv,
                      input tst_e s3, input logic [3:0] aop, input logic ext,
                      input tst_e s4, input string nm);
    cyc(0, 0, op, fn, rv, FETCH, 4'h0, 0, 0, {nm, "_fetch"});
    cyc(0, 0, op, fn, rv, DECODE, 4'h0, 0, 0, {nm, "_decode"});
    cyc(0, 0, 6'h3F, 6'h3F, 5'h1F, s3, aop, ext, 0, {nm, "_exec"});
    cyc(0, 0, 6'h3F, 6'h3F, 5'h1F, s4, 4'h0, 0, 0, {nm, "_wb"});
  endtask

  task automatic t_lw(input string nm);
    cyc(0, 0, 6'h23, 6'h00, 5'h00, FETCH, 4'h0, 0, 0, {nm, "_fetch"});
    cyc(0, 0, 6'h23, 6'h00, 5'h00, DECODE, 4'h0, 0, 0, {nm, "_decode"});
    cyc(0, 0, 6'h2B, 6'h00, 5'h00, MEM_ADDR, 4'h0, 0, 0, {nm, "_addr"});
    cyc(0, 0, 6'h2B, 6'h00, 5'h00, MEM_RD, 4'h0, 0, 0, {nm, "_memrd"});
    cyc(0, 0, 6'h2B, 6'h00, 5'h00, MEM_WB, 4'h0, 0, 0, {nm, "_memwb"});
  endtask

  task automatic seq_ill(input logic [5:0] op, input logic [4:0] rv, input string nm);
    cyc(0, 0, op, 6'h00, rv, FETCH, 4'h0, 0, 0, {nm, "_fetch"});
    cyc(0, 0, op, 6'h00, rv, DECODE, 4'h0, 0, 1, {nm, "_decode"});
  endtask

  logic [3:0] iaop [8];

  initial begin
    iaop = '{4'h3, 4'h4, 4'h9, 4'hA, 4'h5, 4'h6, 4'h7, 4'h8};

    cyc(0, 1, 6'h00, 6'h00, 5'h00, RST, 4'h0, 0, 0, "reset_hold");
    t_lw("lw");
    seq4(6'h00, 6'h20, 5'h00, R_EX, 4'h2, 0, R_WB, "add");
    seq3(6'h00, 6'h08, 5'h00, JR, 4'h0, "jr");
    seq3(6'h00, 6'h09, 5'h00, JALR, 4'h0, "jalr");
    seq3(6'h02, 6'h00, 5'h00, JUMP, 4'h0, "j");
    seq3(6'h03, 6'h00, 5'h00, JAL, 4'h0, "jal");

    for (int i = 0; i < 8; i++) begin
      logic [5:0] op;
      op = 6'h08 + 6'(i);
      seq4(op, 6'h00, 5'h00, I_EX, iaop[i], (op >= 6'h0C && op <= 6'h0E), I_WB,
           $sformatf("itype_%02h", op));
    end

    seq3(6'h04, 6'h00, 5'h00, BRANCH, 4'h1, "beq");
    seq3(6'h05, 6'h00, 5'h00, BRANCH, 4'hB, "bne");
    seq3(6'h06, 6'h00, 5'h00, BRANCH, 4'hD, "blez");
    seq3(6'h07, 6'h00, 5'h00, BRANCH, 4'hC, "bgtz");
    seq3(6'h01, 6'h00, 5'h00, BRANCH, 4'hE, "bltz");
    seq3(6'h01, 6'h00, 5'h01, BRANCH, 4'hF, "bgez");
    seq_ill(6'h01, 5'h02, "regimm_rt2");
    seq_ill(6'h3F, 5'h00, "op3f");

    // sw, with reset asserted in the middle of MEM_WR.
    cyc(0, 0, 6'h2B, 6'h00, 5'h00, FETCH, 4'h0, 0, 0, "sw_fetch");
    cyc(0, 0, 6'h2B, 6'h00, 5'h00, DECODE, 4'h0, 0, 0, "sw_decode");
    cyc(0, 0, 6'h23, 6'h00, 5'h00, MEM_ADDR, 4'h0, 0, 0, "sw_addr");
    cyc(0, 0, 6'h23, 6'h00, 5'h00, MEM_WR, 4'h0, 0, 0, "sw_memwr");
    @(negedge clk);
    #1 rst_m = 1'b1;
    #1 check(act_m, exp_of(RST, 4'h0, 0, 0), "rst_mid_memwr");
    cyc(0, 1, 6'h23, 6'h00, 5'h00, RST, 4'h0, 0, 0, "rst_held");
    t_lw("lw_after_rst");

    // Trapping instance: illegal opcode enters HALT until reset.
    cyc(1, 1, 6'h00, 6'h00, 5'h00, RST, 4'h0, 0, 0, "trap_reset");
    cyc(1, 0, 6'h3F, 6'h00, 5'h00, FETCH, 4'h0, 0, 0, "trap_fetch");
    cyc(1, 0, 6'h3F, 6'h00, 5'h00, DECODE, 4'h0, 0, 1, "trap_decode");
    for (int i = 0; i < 20; i++)
      cyc(1, 0, 6'h00, 6'h00, 5'h00, HALT, 4'h0, 0, 0, $sformatf("trap_halt_%0d", i));
    cyc(1, 1, 6'h00, 6'h00, 5'h00, RST, 4'h0, 0, 0, "trap_rst");
    cyc(1, 0, 6'h00, 6'h00, 5'h00, FETCH, 4'h0, 0, 0, "trap_release");

    repeat (3) @(posedge clk);
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
